// File: rtl/tdma_nd_midend_if.sv
// Job-side and burst-side handshake bundle of the N-dimensional DMA midend.
// The master side issues jobs and accepts bursts; the slave side is the midend.
interface tdma_nd_midend_if #(
    parameter int unsigned NumDims   = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned LenWidth  = 32,
    parameter int unsigned RepWidth  = 32
);
    // ND job request
    logic                                  nd_valid_i;
    logic                                  nd_ready_o;
    logic [LenWidth-1:0]                   nd_len_i;
    logic [AddrWidth-1:0]                  nd_src_addr_i;
    logic [AddrWidth-1:0]                  nd_dst_addr_i;
    logic [NumDims-2:0][RepWidth-1:0]      nd_reps_i;
    logic [NumDims-2:0][AddrWidth-1:0]     nd_src_strides_i;
    logic [NumDims-2:0][AddrWidth-1:0]     nd_dst_strides_i;

    // 1D burst stream
    logic                                  burst_valid_o;
    logic                                  burst_ready_i;
    logic [AddrWidth-1:0]                  burst_src_addr_o;
    logic [AddrWidth-1:0]                  burst_dst_addr_o;
    logic [LenWidth-1:0]                   burst_len_o;
    logic                                  burst_last_o;

    // Status
    logic                                  done_o;
    logic                                  busy_o;

    modport master (
        output nd_valid_i, nd_len_i, nd_src_addr_i, nd_dst_addr_i,
               nd_reps_i, nd_src_strides_i, nd_dst_strides_i, burst_ready_i,
        input  nd_ready_o, burst_valid_o, burst_src_addr_o, burst_dst_addr_o,
               burst_len_o, burst_last_o, done_o, busy_o
    );

    modport slave (
        input  nd_valid_i, nd_len_i, nd_src_addr_i, nd_dst_addr_i,
               nd_reps_i, nd_src_strides_i, nd_dst_strides_i, burst_ready_i,
        output nd_ready_o, burst_valid_o, burst_src_addr_o, burst_dst_addr_o,
               burst_len_o, burst_last_o, done_o, busy_o
    );
endinterface

// File: rtl/tdma_nd_midend.sv
// N-dimensional DMA midend: expands one ND job into a stream of 1D bursts in
// odometer order (dim 2 fastest). Addresses are kept per nesting level so a
// roll-over only adds one stride and copies it down; no multipliers needed.
module tdma_nd_midend #(
    parameter int unsigned NumDims   = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned LenWidth  = 32,
    parameter int unsigned RepWidth  = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    tdma_nd_midend_if.slave bus
);
    localparam int OuterDims = int'(NumDims) - 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]                          state_q;
    logic [LenWidth-1:0]                 len_q;
    logic                                done_q;
    logic [OuterDims-1:0][RepWidth-1:0]  cnt_q;
    logic [OuterDims-1:0][RepWidth-1:0]  max_q;
    logic [OuterDims-1:0][AddrWidth-1:0] src_stride_q;
    logic [OuterDims-1:0][AddrWidth-1:0] dst_stride_q;
    // Level k holds base + sum over j >= k of i_j * stride_j; level 0 is the output.
    logic [OuterDims-1:0][AddrWidth-1:0] src_lvl_q;
    logic [OuterDims-1:0][AddrWidth-1:0] dst_lvl_q;

    logic [OuterDims-1:0]                at_max;
    logic [OuterDims-1:0]                adv;
    logic [OuterDims-1:0]                wrap;
    logic                                carry;
    logic                                all_max;
    logic [AddrWidth-1:0]                src_run;
    logic [AddrWidth-1:0]                dst_run;
    logic [OuterDims-1:0][AddrWidth-1:0] src_lvl_d;
    logic [OuterDims-1:0][AddrWidth-1:0] dst_lvl_d;

    // Odometer carry chain and next per-level addresses for the next burst.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        carry     = 1'b1;
        at_max    = '0;
        adv       = '0;
        wrap      = '0;
        src_run   = '0;
        dst_run   = '0;
        src_lvl_d = src_lvl_q;
        dst_lvl_d = dst_lvl_q;
        for (int k = 0; k < OuterDims; k++) begin
            at_max[k] = (cnt_q[k] == max_q[k]);
            adv[k]    = carry & ~at_max[k];
            wrap[k]   = carry & at_max[k];
            carry     = carry & at_max[k];
        end
        all_max = carry;
        // Walk top-down so a wrapped level picks up the advanced level above it.
        for (int k = OuterDims - 1; k >= 0; k--) begin
            if (adv[k]) begin
                src_lvl_d[k] = src_lvl_q[k] + src_stride_q[k];
                dst_lvl_d[k] = dst_lvl_q[k] + dst_stride_q[k];
                src_run      = src_lvl_d[k];
                dst_run      = dst_lvl_d[k];
            end else if (wrap[k]) begin
                src_lvl_d[k] = src_run;
                dst_lvl_d[k] = dst_run;
            end
        end
    end

    // Job acceptance, burst sequencing and the completion pulse.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments only.
        if (rst_i) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
            max_q        <= '0;
            src_stride_q <= '0;
            dst_stride_q <= '0;
            src_lvl_q    <= '0;
            dst_lvl_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (bus.nd_valid_i) begin
                    len_q        <= bus.nd_len_i;
                    src_stride_q <= bus.nd_src_strides_i;
                    dst_stride_q <= bus.nd_dst_strides_i;
                    for (int k = 0; k < OuterDims; k++) begin
                        // Reps of 0 and 1 both mean a single iteration.
                        max_q[k]     <= (bus.nd_reps_i[k] > RepWidth'(1))
                                        ? bus.nd_reps_i[k] - RepWidth'(1) : '0;
                        cnt_q[k]     <= '0;
                        src_lvl_q[k] <= bus.nd_src_addr_i;
                        dst_lvl_q[k] <= bus.nd_dst_addr_i;
                    end
                    if (bus.nd_len_i != '0) begin
                        state_q <= ST_EMIT;
                    end else begin
                        done_q  <= 1'b1;
                    end
                end
            end else if (bus.burst_ready_i) begin
                if (all_max) begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end else begin
                    for (int k = 0; k < OuterDims; k++) begin
                        if (adv[k]) begin
                            cnt_q[k] <= cnt_q[k] + RepWidth'(1);
                        end else if (wrap[k]) begin
                            cnt_q[k] <= '0;
                        end
                    end
                    src_lvl_q <= src_lvl_d;
                    dst_lvl_q <= dst_lvl_d;
                end
            end
        end
    end

    assign bus.nd_ready_o       = (state_q == ST_IDLE);
    assign bus.busy_o           = (state_q == ST_EMIT);
    assign bus.burst_valid_o    = (state_q == ST_EMIT);
    assign bus.burst_last_o     = (state_q == ST_EMIT) && all_max;
    assign bus.burst_src_addr_o = src_lvl_q[0];
    assign bus.burst_dst_addr_o = dst_lvl_q[0];
    assign bus.burst_len_o      = len_q;
    assign bus.done_o           = done_q;
endmodule
